// File: rtl/seg_scan_decoder.sv
// Purpose : recover hex digits from a scanned, active-low 7-segment bus
//           (seg_n + an_n) and publish them after repeated identical frames.
// Latency : a digit is sampled on the SETTLE_CYCLES-th stable edge. A frame
//           completed at edge E is compared at E+1, where value, digit_err
//           and valid change. update is high for the cycle after E+1.
// Backpressure: none. The display bus cannot be stalled, so digits that
//           dwell too briefly are simply never sampled.
// Ports   : clk, rst_n (async active-low), seg_n[6:0] (bit0=a..bit6=g),
//           an_n[NUM_DIGITS-1:0] (one low bit selects a digit),
//           value[4*NUM_DIGITS-1:0], digit_err[NUM_DIGITS-1:0], valid, update.
module seg_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int STABLE_FRAMES = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    valid,
  output logic                    update
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int FW = $clog2(STABLE_FRAMES + 1);
  localparam int WW = 5 * NUM_DIGITS;  // {errors, nibbles}

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

  // Inverse of the segment encoder. Returns {err, nibble}.
  function automatic logic [4:0] decode(input logic [6:0] s_n);
    logic [6:0] s;
    s = ~s_n;
    case (s)
      7'h3F: decode = 5'h00;
      7'h06: decode = 5'h01;
      7'h5B: decode = 5'h02;
      7'h4F: decode = 5'h03;
      7'h66: decode = 5'h04;
      7'h6D: decode = 5'h05;
      7'h7D: decode = 5'h06;
      7'h07: decode = 5'h07;
      7'h7F: decode = 5'h08;
      7'h6F: decode = 5'h09;
      7'h77: decode = 5'h0A;
      7'h7C: decode = 5'h0B;
      7'h39: decode = 5'h0C;
      7'h5E: decode = 5'h0D;
      7'h79: decode = 5'h0E;
      7'h71: decode = 5'h0F;
      default: decode = 5'h10;
    endcase
  endfunction

  state_t                  st;
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           cur_idx;
  logic [6:0]              cur_seg;
  logic [4*NUM_DIGITS-1:0] nib_buf, nib_next;
  logic [NUM_DIGITS-1:0]   err_buf, err_next, seen, seen_next;
  logic [WW-1:0]           frm, cand;
  logic                    frm_vld;
  logic [FW-1:0]           fcnt, fcnt_next;
  logic                    commit;

  // Anode qualification: exactly one low bit.
  logic          an_ok;
  logic [IW-1:0] an_idx;
  logic [3:0]    nlow;
  always_comb begin
    nlow   = 4'd0;
    an_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_n[i]) begin
        nlow   = nlow + 4'd1;
        an_idx = IW'(i);
      end
    end
    an_ok = (nlow == 4'd1);
  end

  logic       same;
  logic [4:0] dec;
  assign same = (an_idx == cur_idx) && (seg_n == cur_seg);
  assign dec  = decode(cur_seg);

  // Frame buffer contents if the latched digit were sampled this cycle.
  always_comb begin
    nib_next = nib_buf;
    err_next = err_buf;
    seen_next = seen;
    nib_next[4*cur_idx +: 4] = dec[3:0];
    err_next[cur_idx]        = dec[4];
    seen_next[cur_idx]       = 1'b1;
  end

  // Scan tracker. cnt counts stable edges since the latch; the edge on
  // which it would reach SETTLE_CYCLES is the sample edge. Any change
  // (including one on a would-be sample edge) restarts settling instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= IDLE;
      cnt     <= '0;
      cur_idx <= '0;
      cur_seg <= '0;
      nib_buf <= '0;
      err_buf <= '0;
      seen    <= '0;
      frm     <= '0;
      frm_vld <= 1'b0;
    end else begin
      frm_vld <= 1'b0;
      if (!an_ok) begin
        st <= IDLE;  // blanking keeps seen and the partial frame
      end else begin
        case (st)
          IDLE: begin
            st      <= SETTLE;
            cnt     <= '0;
            cur_idx <= an_idx;
            cur_seg <= seg_n;
          end
          SETTLE: begin
            if (!same) begin
              cnt     <= '0;
              cur_idx <= an_idx;
              cur_seg <= seg_n;
            end else if (cnt == CW'(SETTLE_CYCLES - 1)) begin
              st      <= HELD;
              nib_buf <= nib_next;
              err_buf <= err_next;
              if (&seen_next) begin
                frm     <= {err_next, nib_next};
                frm_vld <= 1'b1;
                seen    <= '0;
              end else begin
                seen    <= seen_next;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          HELD: begin
            if (!same) begin
              st      <= SETTLE;
              cnt     <= '0;
              cur_idx <= an_idx;
              cur_seg <= seg_n;
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

  // Stability filter: saturating run length of identical frames.
  always_comb begin
    if (frm == cand)
      fcnt_next = (fcnt == FW'(STABLE_FRAMES)) ? fcnt : fcnt + 1'b1;
    else
      fcnt_next = FW'(1);
    commit = frm_vld && (fcnt_next >= FW'(STABLE_FRAMES)) &&
             (!valid || (frm != {digit_err, value}));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand      <= '0;
      fcnt      <= '0;
      value     <= '0;
      digit_err <= '0;
      valid     <= 1'b0;
      update    <= 1'b0;
    end else begin
      update <= commit;
      if (frm_vld) begin
        cand <= frm;
        fcnt <= fcnt_next;
      end
      if (commit) begin
        value     <= frm[4*NUM_DIGITS-1:0];
        digit_err <= frm[WW-1:4*NUM_DIGITS];
        valid     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Purpose : directed checks of seg_scan_decoder (4 digits, settle 2, 3 frames).
// Latency : inputs driven on falling edges, outputs checked on falling edges.
// Backpressure: n/a.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic [15:0] value;
  logic [3:0]  digit_err;
  logic        valid;
  logic        update;

  int tests = 0;
  int fails = 0;
  int upd_cnt = 0;

  // seg_n patterns (active-low) for digits 0..9
  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30,
                         S4 = 7'h19, S5 = 7'h12, S6 = 7'h02, S7 = 7'h78,
                         S8 = 7'h00, S9 = 7'h10, SOFF = 7'h7F;

  seg_scan_decoder #(.NUM_DIGITS(4), .SETTLE_CYCLES(2), .STABLE_FRAMES(3)) dut (
    .clk(clk), .rst_n(rst_n), .seg_n(seg_n), .an_n(an_n),
    .value(value), .digit_err(digit_err), .valid(valid), .update(update)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (update === 1'b1) upd_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold digit i with pattern s for dwell rising edges; entered at a falling edge.
  task automatic dig(input int i, input logic [6:0] s, input int dwell);
    logic [3:0] sel;
    sel   = 4'b0001 << i;
    an_n  = ~sel;
    seg_n = s;
    repeat (dwell) @(negedge clk);
  endtask

  task automatic blank(input logic [3:0] a, input int n);
    an_n = a;
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input logic [6:0] s0, s1, s2, s3);
    dig(0, s0, 8); dig(1, s1, 8); dig(2, s2, 8); dig(3, s3, 8);
  endtask

  initial begin
    rst_n = 1'b0; an_n = 4'hF; seg_n = SOFF;
    #12;
    check("rst_value", value, 0);
    check("rst_err", digit_err, 0);
    check("rst_valid", valid, 0);
    check("rst_update", update, 0);
    @(negedge clk); rst_n = 1'b1;

    // Clean scan of "1234" with exact commit timing on the third frame.
    frame(S4, S3, S2, S1);
    frame(S4, S3, S2, S1);
    check("two_frames_valid", valid, 0);
    check("two_frames_value", value, 0);
    dig(0, S4, 8); dig(1, S3, 8); dig(2, S2, 8); dig(3, S1, 3);  // last edge is E
    check("at_E_valid", valid, 0);
    check("at_E_update", update, 0);
    blank(4'hF, 1);  // E+1
    check("E1_value", value, 16'h1234);
    check("E1_err", digit_err, 0);
    check("E1_valid", valid, 1);
    check("E1_update", update, 1);
    blank(4'hF, 1);  // E+2
    check("E2_update", update, 0);
    blank(4'hF, 4);
    check("upd_once_1234", upd_cnt, 1);

    // Value change with glitches, and an interleaved 9999 frame.
    dig(0, S8, 8);
    dig(1, S7, 1); dig(1, S9, 1); dig(1, S7, 6);            // glitch before sample
    dig(2, S6, 4); dig(2, S9, 1); dig(2, S6, 4);            // glitch after sample
    dig(3, S5, 8);
    frame(S8, S7, S6, S5);
    check("chg_hold_2frames", value, 16'h1234);
    frame(S9, S9, S9, S9);
    check("chg_hold_9999", value, 16'h1234);
    frame(S8, S7, S6, S5);
    frame(S8, S7, S6, S5);
    check("chg_hold_after_interleave", value, 16'h1234);
    frame(S8, S7, S6, S5);
    check("chg_value_5678", value, 16'h5678);
    check("chg_upd_cnt", upd_cnt, 2);

    // Undecodable pattern on digit 2.
    frame(S8, S7, SOFF, S5);
    frame(S8, S7, SOFF, S5);
    check("bad_hold_value", value, 16'h5678);
    check("bad_hold_err", digit_err, 0);
    frame(S8, S7, SOFF, S5);
    check("bad_value", value, 16'h5078);
    check("bad_err", digit_err, 4'b0100);
    check("bad_upd_cnt", upd_cnt, 3);

    // Anode faults between digits; partial frames survive blanking.
    for (int f = 0; f < 3; f++) begin
      dig(0, S4, 8); blank(4'hF, 3);
      dig(1, S3, 8); blank(4'h0, 3);
      dig(2, S2, 8); blank(4'hF, 10);
      dig(3, S1, 8); blank(4'hF, 2);
      if (f == 1) check("fault_hold", value, 16'h5078);
    end
    check("fault_value", value, 16'h1234);
    check("fault_err", digit_err, 0);
    check("fault_upd_cnt", upd_cnt, 4);

    // Digit 2 dwells only 2 cycles: never sampled, no frame completes.
    for (int f = 0; f < 3; f++) begin
      dig(0, S9, 8); dig(1, S9, 8); dig(2, S9, 2); dig(3, S9, 8);
    end
    check("short_value", value, 16'h1234);
    check("short_upd_cnt", upd_cnt, 4);

    // Asynchronous reset mid-frame while valid is high.
    dig(0, S4, 8); dig(1, S3, 4);
    check("pre_rst_valid", valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_value", value, 0);
    check("arst_err", digit_err, 0);
    check("arst_valid", valid, 0);
    check("arst_update", update, 0);
    @(negedge clk); rst_n = 1'b1;
    frame(S4, S3, S2, S1);
    frame(S4, S3, S2, S1);
    check("post_rst_valid_2", valid, 0);
    frame(S4, S3, S2, S1);
    check("post_rst_valid_3", valid, 1);
    check("post_rst_value", value, 16'h1234);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
